// File: rtl/mc_ctrl_if.sv
// Handshake and control bundle between the multi-cycle control FSM and the datapath/memory.
// The control unit takes the master side; the datapath and memory take the slave side.
interface mc_ctrl_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               overflow;
    logic               mem_ack;
    logic               mem_req;
    logic               mem_we;
    logic               pc_wr;
    logic               ir_wr;
    logic               gpr_wr;
    logic               alu_src;
    logic               byte_sel;
    logic [1:0]         gpr_dst;
    logic [1:0]         mem2reg;
    logic [1:0]         ext_op;
    logic [1:0]         npc_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               trap;
    logic [1:0]         trap_cause;
    logic [4:0]         state_o;

    modport master (
        input  op, funct, zero, overflow, mem_ack,
        output mem_req, mem_we, pc_wr, ir_wr, gpr_wr, alu_src, byte_sel,
               gpr_dst, mem2reg, ext_op, npc_sel, alu_op, trap, trap_cause, state_o
    );

    modport slave (
        output op, funct, zero, overflow, mem_ack,
        input  mem_req, mem_we, pc_wr, ir_wr, gpr_wr, alu_src, byte_sel,
               gpr_dst, mem2reg, ext_op, npc_sel, alu_op, trap, trap_cause, state_o
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS32 control unit: state register, next-state logic, per-state control decode,
// memory req/ack wait states with bounded timeout, and a sticky trap for illegal ops / bus timeouts.
module mc_ctrl_fsm #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int BYTE_EN     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_ctrl_if.master    bus
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    typedef enum logic [4:0] {
        S_INIT     = 5'd0,  S_FETCH  = 5'd1,  S_DECODE = 5'd2,  S_EXE_R = 5'd3,
        S_WB_R     = 5'd4,  S_EXE_I  = 5'd5,  S_WB_I   = 5'd6,  S_MEM_ADDR = 5'd7,
        S_MEM_RD   = 5'd8,  S_MEM_WR = 5'd9,  S_MEM_WB = 5'd10, S_BEQ   = 5'd11,
        S_JUMP     = 5'd12, S_JAL    = 5'd13, S_JR     = 5'd14, S_TRAP  = 5'd15
    } state_e;

    typedef enum logic [3:0] {
        K_ADDU = 4'd0,  K_SUBU = 4'd1,  K_SLT = 4'd2,  K_JR  = 4'd3,
        K_ORI  = 4'd4,  K_ADDIU = 4'd5, K_ADDI = 4'd6, K_LUI = 4'd7,
        K_LW   = 4'd8,  K_SW   = 4'd9,  K_LB  = 4'd10, K_SB  = 4'd11,
        K_BEQ  = 4'd12, K_J    = 4'd13, K_JAL = 4'd14, K_ILL = 4'd15
    } kind_e;

    state_e             state_q, state_d;
    kind_e              kind_q, kind_s, kind_n;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cause_q, cause_d;
    logic               trap_q;
    logic               wait_s, timeout_s;

    logic               mem_req_s, mem_we_s, pc_wr_s, gpr_wr_s, alu_src_s, byte_sel_s, ovf_gate_s;
    logic [1:0]         gpr_dst_s, mem2reg_s, ext_op_s, npc_sel_s;
    logic [ALUOP_W-1:0] alu_op_s;
    logic               mem_req_q, mem_we_q, pc_wr_q, gpr_wr_q, alu_src_q, byte_sel_q, ovf_gate_q;
    logic [1:0]         gpr_dst_q, mem2reg_q, ext_op_q, npc_sel_q;
    logic [ALUOP_W-1:0] alu_op_q;

    // Classify the live IR fields into an instruction kind.
    always_comb begin
        kind_s = K_ILL;
        case (bus.op)
            6'h00: begin
                case (bus.funct)
                    6'h21:   kind_s = K_ADDU;
                    6'h23:   kind_s = K_SUBU;
                    6'h2A:   kind_s = K_SLT;
                    6'h08:   kind_s = K_JR;
                    default: kind_s = K_ILL;
                endcase
            end
            6'h0D:   kind_s = K_ORI;
            6'h09:   kind_s = K_ADDIU;
            6'h08:   kind_s = K_ADDI;
            6'h0F:   kind_s = K_LUI;
            6'h23:   kind_s = K_LW;
            6'h2B:   kind_s = K_SW;
            6'h20:   kind_s = (BYTE_EN != 0) ? K_LB : K_ILL;
            6'h28:   kind_s = (BYTE_EN != 0) ? K_SB : K_ILL;
            6'h04:   kind_s = K_BEQ;
            6'h02:   kind_s = K_J;
            6'h03:   kind_s = K_JAL;
            default: kind_s = K_ILL;
        endcase
    end

    // Next-state, wait counter and trap cause; the decode is captured only while in DECODE.
    always_comb begin
        kind_n    = kind_q;
        state_d   = state_q;
        cause_d   = cause_q;
        wait_s    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        timeout_s = (MEM_TIMEOUT != 0) && wait_s && !bus.mem_ack && (cnt_q == CNT_LAST);
        if (wait_s && !bus.mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        if (state_q == S_DECODE) begin
            kind_n = kind_s;
        end else begin
            kind_n = kind_q;
        end
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else if (bus.mem_ack) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (kind_s)
                    K_ADDU, K_SUBU, K_SLT:        state_d = S_EXE_R;
                    K_JR:                         state_d = S_JR;
                    K_ORI, K_ADDIU, K_ADDI, K_LUI: state_d = S_EXE_I;
                    K_LW, K_SW, K_LB, K_SB:       state_d = S_MEM_ADDR;
                    K_BEQ:                        state_d = S_BEQ;
                    K_J:                          state_d = S_JUMP;
                    K_JAL:                        state_d = S_JAL;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXE_R:  state_d = S_WB_R;
            S_EXE_I:  state_d = S_WB_I;
            S_MEM_ADDR: begin
                if ((kind_q == K_LW) || (kind_q == K_LB)) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else if (bus.mem_ack) begin
                    state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_WB_R, S_WB_I, S_MEM_WB, S_BEQ, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_INIT;
        endcase
    end

    // Moore control values for the state being entered, so they leave the block registered.
    always_comb begin
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        pc_wr_s    = 1'b0;
        gpr_wr_s   = 1'b0;
        alu_src_s  = 1'b0;
        byte_sel_s = 1'b0;
        gpr_dst_s  = 2'b00;
        mem2reg_s  = 2'b00;
        ext_op_s   = 2'b00;
        npc_sel_s  = 2'b00;
        alu_op_s   = ALUOP_W'(0);
        ovf_gate_s = (state_d == S_WB_I) && (kind_n == K_ADDI);
        case (state_d)
            S_FETCH:  mem_req_s = 1'b1;
            S_EXE_R: begin
                case (kind_n)
                    K_SUBU:  alu_op_s = ALUOP_W'(1);
                    K_SLT:   alu_op_s = ALUOP_W'(3);
                    default: alu_op_s = ALUOP_W'(0);
                endcase
            end
            S_WB_R: begin
                gpr_wr_s  = 1'b1;
                gpr_dst_s = 2'b01;
            end
            S_EXE_I: begin
                alu_src_s = 1'b1;
                case (kind_n)
                    K_ORI: begin
                        ext_op_s = 2'b00;
                        alu_op_s = ALUOP_W'(2);
                    end
                    K_LUI: begin
                        ext_op_s = 2'b10;
                        alu_op_s = ALUOP_W'(4);
                    end
                    default: begin
                        ext_op_s = 2'b01;
                        alu_op_s = ALUOP_W'(0);
                    end
                endcase
            end
            S_WB_I:   gpr_wr_s = 1'b1;
            S_MEM_ADDR: begin
                alu_src_s = 1'b1;
                ext_op_s  = 2'b01;
            end
            S_MEM_RD: begin
                mem_req_s  = 1'b1;
                byte_sel_s = (kind_n == K_LB);
            end
            S_MEM_WR: begin
                mem_req_s  = 1'b1;
                mem_we_s   = 1'b1;
                byte_sel_s = (kind_n == K_SB);
            end
            S_MEM_WB: begin
                gpr_wr_s  = 1'b1;
                mem2reg_s = 2'b01;
            end
            S_BEQ: begin
                alu_op_s  = ALUOP_W'(1);
                npc_sel_s = 2'b01;
            end
            S_JUMP: begin
                pc_wr_s   = 1'b1;
                npc_sel_s = 2'b10;
            end
            S_JAL: begin
                pc_wr_s   = 1'b1;
                gpr_wr_s  = 1'b1;
                gpr_dst_s = 2'b10;
                mem2reg_s = 2'b10;
                npc_sel_s = 2'b10;
            end
            S_JR: begin
                pc_wr_s   = 1'b1;
                npc_sel_s = 2'b11;
            end
            default: mem_req_s = 1'b0;
        endcase
    end

    // State, latched decode, wait counter, trap and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            kind_q     <= K_ILL;
            cnt_q      <= '0;
            cause_q    <= 2'b00;
            trap_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            pc_wr_q    <= 1'b0;
            gpr_wr_q   <= 1'b0;
            alu_src_q  <= 1'b0;
            byte_sel_q <= 1'b0;
            ovf_gate_q <= 1'b0;
            gpr_dst_q  <= 2'b00;
            mem2reg_q  <= 2'b00;
            ext_op_q   <= 2'b00;
            npc_sel_q  <= 2'b00;
            alu_op_q   <= ALUOP_W'(0);
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_n;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            trap_q     <= (state_d == S_TRAP);
            mem_req_q  <= mem_req_s;
            mem_we_q   <= mem_we_s;
            pc_wr_q    <= pc_wr_s;
            gpr_wr_q   <= gpr_wr_s;
            alu_src_q  <= alu_src_s;
            byte_sel_q <= byte_sel_s;
            ovf_gate_q <= ovf_gate_s;
            gpr_dst_q  <= gpr_dst_s;
            mem2reg_q  <= mem2reg_s;
            ext_op_q   <= ext_op_s;
            npc_sel_q  <= npc_sel_s;
            alu_op_q   <= alu_op_s;
        end
    end

    // Only the fetch strobes, the branch decision and the addi overflow veto see live inputs.
    assign bus.pc_wr      = pc_wr_q || ((state_q == S_FETCH) && bus.mem_ack)
                                    || ((state_q == S_BEQ) && bus.zero);
    assign bus.ir_wr      = (state_q == S_FETCH) && bus.mem_ack;
    assign bus.gpr_wr     = gpr_wr_q && !(ovf_gate_q && bus.overflow);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.alu_src    = alu_src_q;
    assign bus.byte_sel   = byte_sel_q;
    assign bus.gpr_dst    = gpr_dst_q;
    assign bus.mem2reg    = mem2reg_q;
    assign bus.ext_op     = ext_op_q;
    assign bus.npc_sel    = npc_sel_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (MEM_TIMEOUT=4, BYTE_EN=1) with hand-computed per-cycle expectations.
module tb_mc_ctrl_fsm;
    localparam logic [4:0] S_INIT = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_EXE_R = 5'd3,
                           S_WB_R = 5'd4, S_EXE_I = 5'd5, S_WB_I = 5'd6, S_MEM_ADDR = 5'd7,
                           S_MEM_RD = 5'd8, S_MEM_WR = 5'd9, S_MEM_WB = 5'd10, S_BEQ = 5'd11,
                           S_JUMP = 5'd12, S_JAL = 5'd13, S_JR = 5'd14, S_TRAP = 5'd15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUOP_W(3)) bus ();

    mc_ctrl_fsm #(.ALUOP_W(3), .MEM_TIMEOUT(4), .BYTE_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    logic [5:0] op_v = 6'h00;
    logic [5:0] fn_v = 6'h00;
    logic [17:0] c_zero, c_fw, c_fa, c_wbr, c_addr, c_rd, c_wb, c_wbi;

    // {mem_req, mem_we, pc_wr, ir_wr, gpr_wr, alu_src, byte_sel, gpr_dst, mem2reg, ext_op, npc_sel, alu_op}
    function automatic logic [17:0] ctl(input logic req, we, pcw, irw, gw, asrc, bsel,
                                        input logic [1:0] gdst, m2r, ext, npc, input logic [2:0] aop);
        return {req, we, pcw, irw, gw, asrc, bsel, gdst, m2r, ext, npc, aop};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.mem_req, bus.mem_we, bus.pc_wr, bus.ir_wr, bus.gpr_wr, bus.alu_src, bus.byte_sel,
                bus.gpr_dst, bus.mem2reg, bus.ext_op, bus.npc_sel, bus.alu_op};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, check state/controls/trap, then advance past the edge.
    task automatic cyc(input string tag, input logic zr, ov, ack,
                       input logic [4:0] st, input logic [17:0] c, input logic [2:0] tr);
        bus.op = op_v; bus.funct = fn_v; bus.zero = zr; bus.overflow = ov; bus.mem_ack = ack;
        #1;
        check_eq({tag, "/state"}, 32'(bus.state_o), 32'(st));
        check_eq({tag, "/ctl"}, 32'(obs()), 32'(c));
        check_eq({tag, "/trap"}, 32'({bus.trap, bus.trap_cause}), 32'(tr));
        @(posedge clk); #1;
    endtask

    task automatic fd(input string tag, input logic [5:0] o, input logic [5:0] f);
        op_v = o; fn_v = f;
        cyc({tag, "_fetch"}, 1'b0, 1'b0, 1'b1, S_FETCH, c_fa, 3'b000);
        cyc({tag, "_dec"},   1'b0, 1'b0, 1'b0, S_DECODE, c_zero, 3'b000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_state", 32'(bus.state_o), 32'(S_INIT));
        check_eq("rst_async_ctl", 32'(obs()), 32'd0);
        check_eq("rst_async_trap", 32'({bus.trap, bus.trap_cause}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("init", 1'b0, 1'b0, 1'b0, S_INIT, c_zero, 3'b000);
    endtask

    initial begin
        c_zero = 18'd0;
        c_fw   = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0);
        c_fa   = ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0);
        c_wbr  = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0);
        c_addr = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 3'd0);
        c_rd   = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0);
        c_wb   = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 3'd0);
        c_wbi  = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0);
        bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.overflow = 1'b0; bus.mem_ack = 1'b0;

        // Reset held 3 cycles, then one INIT cycle.
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", 32'(bus.state_o), 32'(S_INIT));
        check_eq("reset_ctl", 32'(obs()), 32'd0);
        check_eq("reset_trap", 32'({bus.trap, bus.trap_cause}), 32'd0);
        rst_n = 1'b1;
        cyc("init", 1'b0, 1'b0, 1'b0, S_INIT, c_zero, 3'b000);

        // addu
        fd("addu", 6'h00, 6'h21);
        cyc("addu_exe", 1'b0, 1'b0, 1'b0, S_EXE_R, c_zero, 3'b000);
        cyc("addu_wb",  1'b0, 1'b0, 1'b0, S_WB_R, c_wbr, 3'b000);

        // subu, with IR fields scrambled after DECODE to show the decode is latched
        fd("subu", 6'h00, 6'h23);
        op_v = 6'h3F; fn_v = 6'h3F;
        cyc("subu_exe", 1'b0, 1'b0, 1'b0, S_EXE_R,
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1), 3'b000);
        cyc("subu_wb",  1'b0, 1'b0, 1'b0, S_WB_R, c_wbr, 3'b000);

        // slt
        fd("slt", 6'h00, 6'h2A);
        cyc("slt_exe", 1'b0, 1'b0, 1'b0, S_EXE_R,
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd3), 3'b000);
        cyc("slt_wb",  1'b0, 1'b0, 1'b0, S_WB_R, c_wbr, 3'b000);

        // lw with ack on the 4th MEM_RD cycle (exactly at the timeout limit: ack wins)
        fd("lw", 6'h23, 6'h00);
        cyc("lw_addr", 1'b0, 1'b0, 1'b0, S_MEM_ADDR, c_addr, 3'b000);
        for (int i = 0; i < 3; i++) cyc("lw_rdwait", 1'b0, 1'b0, 1'b0, S_MEM_RD, c_rd, 3'b000);
        cyc("lw_rdack", 1'b0, 1'b0, 1'b1, S_MEM_RD, c_rd, 3'b000);
        cyc("lw_wb",    1'b0, 1'b0, 1'b0, S_MEM_WB, c_wb, 3'b000);

        // beq not taken / taken
        fd("beq0", 6'h04, 6'h00);
        cyc("beq0_br", 1'b0, 1'b0, 1'b0, S_BEQ,
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd1), 3'b000);
        fd("beq1", 6'h04, 6'h00);
        cyc("beq1_br", 1'b1, 1'b0, 1'b0, S_BEQ,
            ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd1), 3'b000);

        // addi overflow suppresses write-back; addiu ignores overflow
        fd("addi", 6'h08, 6'h00);
        cyc("addi_exe", 1'b0, 1'b0, 1'b0, S_EXE_I, c_addr, 3'b000);
        cyc("addi_wb",  1'b0, 1'b1, 1'b0, S_WB_I, c_zero, 3'b000);
        fd("addiu", 6'h09, 6'h00);
        cyc("addiu_exe", 1'b0, 1'b0, 1'b0, S_EXE_I, c_addr, 3'b000);
        cyc("addiu_wb",  1'b0, 1'b1, 1'b0, S_WB_I, c_wbi, 3'b000);

        // ori (zero-extend, or) and lui (lui-shift, pass)
        fd("ori", 6'h0D, 6'h00);
        cyc("ori_exe", 1'b0, 1'b0, 1'b0, S_EXE_I,
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd2), 3'b000);
        cyc("ori_wb",  1'b0, 1'b0, 1'b0, S_WB_I, c_wbi, 3'b000);
        fd("lui", 6'h0F, 6'h00);
        cyc("lui_exe", 1'b0, 1'b0, 1'b0, S_EXE_I,
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 3'd4), 3'b000);
        cyc("lui_wb",  1'b0, 1'b0, 1'b0, S_WB_I, c_wbi, 3'b000);

        // lb (byte read) and sw (word write)
        fd("lb", 6'h20, 6'h00);
        cyc("lb_addr", 1'b0, 1'b0, 1'b0, S_MEM_ADDR, c_addr, 3'b000);
        cyc("lb_rd", 1'b0, 1'b0, 1'b1, S_MEM_RD,
            ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0), 3'b000);
        cyc("lb_wb", 1'b0, 1'b0, 1'b0, S_MEM_WB, c_wb, 3'b000);
        fd("sw", 6'h2B, 6'h00);
        cyc("sw_addr", 1'b0, 1'b0, 1'b0, S_MEM_ADDR, c_addr, 3'b000);
        cyc("sw_wr", 1'b0, 1'b0, 1'b1, S_MEM_WR,
            ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0), 3'b000);

        // j, jal
        fd("j", 6'h02, 6'h00);
        cyc("j_exe", 1'b0, 1'b0, 1'b0, S_JUMP,
            ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 3'd0), 3'b000);
        fd("jal", 6'h03, 6'h00);
        cyc("jal_exe", 1'b0, 1'b0, 1'b0, S_JAL,
            ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 2'b10, 3'd0), 3'b000);

        // jr, fetched with ack on the 4th FETCH cycle (no trap)
        op_v = 6'h00; fn_v = 6'h08;
        for (int i = 0; i < 3; i++) cyc("jr_fwait", 1'b0, 1'b0, 1'b0, S_FETCH, c_fw, 3'b000);
        cyc("jr_fack", 1'b0, 1'b0, 1'b1, S_FETCH, c_fa, 3'b000);
        cyc("jr_dec",  1'b0, 1'b0, 1'b0, S_DECODE, c_zero, 3'b000);
        cyc("jr_exe",  1'b0, 1'b0, 1'b0, S_JR,
            ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 3'd0), 3'b000);

        // Illegal opcode -> TRAP cause 01, sticky
        fd("ill", 6'h3F, 6'h00);
        cyc("ill_trap",  1'b0, 1'b0, 1'b0, S_TRAP, c_zero, 3'b101);
        cyc("ill_stay",  1'b0, 1'b0, 1'b1, S_TRAP, c_zero, 3'b101);

        // Bus timeout in FETCH -> TRAP cause 10 after 4 wait cycles
        do_reset();
        for (int i = 0; i < 4; i++) cyc("to_fwait", 1'b0, 1'b0, 1'b0, S_FETCH, c_fw, 3'b000);
        cyc("to_trap", 1'b0, 1'b0, 1'b0, S_TRAP, c_zero, 3'b110);
        cyc("to_stay", 1'b0, 1'b0, 1'b1, S_TRAP, c_zero, 3'b110);

        // Reset asserted mid-access drops mem_req without a clock edge
        do_reset();
        fd("lw2", 6'h23, 6'h00);
        cyc("lw2_addr", 1'b0, 1'b0, 1'b0, S_MEM_ADDR, c_addr, 3'b000);
        bus.mem_ack = 1'b0;
        #1;
        check_eq("midacc_req_before", 32'(bus.mem_req), 32'd1);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multi-cycle MIPS32 control unit that owns its state register, next-state logic and per-state control decode. Memory accesses use a req/ack handshake with wait states and a bounded timeout. Illegal opcodes and bus timeouts end in a trap state. Sits between the IR opcode/funct fields and the datapath (PC, IR, GPR file, ALU, extender, data memory).

Parameters:
ALUOP_W, 3, width of alu_op.
MEM_TIMEOUT, 16, max cycles waiting for mem_ack before trap; 0 disables timeout.
BYTE_EN, 1, 1 = lb/sb legal; 0 = lb/sb decode as illegal.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU signed overflow (addi only)
mem_ack  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write (sw/sb)
pc_wr, ir_wr, gpr_wr, alu_src, byte_sel  out  1 each  datapath enables/selects
gpr_dst, mem2reg, ext_op, npc_sel  out  2 each  00 rt/alu/zero-ext/pc+4; 01 rd/mem/sign-ext/branch; 10 r31/pc/lui-shift/jump; 11 jr
alu_op  out  ALUOP_W  0 add, 1 sub, 2 or, 3 slt, 4 lui-pass
trap  out  1  sticky; set in TRAP state
trap_cause  out  2  01 illegal opcode, 10 bus timeout, 11 reserved
state_o  out  5  current state code, for debug

Behaviour:
- Reset (rst_n=0, asynchronous): state=INIT, wait counter=0, trap=0, trap_cause=00. All outputs 0 while in INIT. INIT -> FETCH unconditionally on the next clock after release.
- Moore outputs decoded from state. Exceptions: pc_wr/ir_wr in FETCH are qualified by mem_ack; pc_wr in BEQ = zero; gpr_wr in WB_I is forced 0 when overflow=1 on addi.
- States and transitions:
  - FETCH: mem_req=1. If mem_ack: ir_wr=1, pc_wr=1, npc_sel=00, -> DECODE. Otherwise stay.
  - DECODE: -> EXE_R (op=0, funct in addu 21h/subu 23h/slt 2Ah); -> JR (op=0, funct=08h); -> EXE_I (ori 0Dh, addiu 09h, addi 08h, lui 0Fh); -> MEM_ADDR (lw 23h, sw 2Bh, lb 20h, sb 28h); -> BEQ (04h); -> JUMP (02h); -> JAL (03h); anything else -> TRAP with cause 01.
  - EXE_R -> WB_R: gpr_dst=01, mem2reg=00, gpr_wr=1 in WB_R, then -> FETCH.
  - EXE_I -> WB_I: alu_src=1; ext_op is 00 for ori, 10 for lui, 01 otherwise; gpr_dst=00. WB_I -> FETCH.
  - MEM_ADDR: alu_src=1, ext_op=01. Loads -> MEM_RD; stores -> MEM_WR.
  - MEM_RD / MEM_WR: mem_req=1, mem_we=(MEM_WR), byte_sel=1 for lb/sb. Hold until mem_ack. On ack: MEM_RD -> MEM_WB; MEM_WR -> FETCH.
  - MEM_WB: gpr_wr=1, mem2reg=01, gpr_dst=00, -> FETCH.
  - BEQ: alu_op=1, npc_sel=01, -> FETCH.
  - JUMP: pc_wr=1, npc_sel=10, -> FETCH.
  - JAL: as JUMP, plus gpr_wr=1, gpr_dst=10, mem2reg=10, -> FETCH.
  - JR: pc_wr=1, npc_sel=11, -> FETCH.
  - TRAP: all enables 0. Remains in TRAP until reset.
- Wait counter: clog2(MEM_TIMEOUT+1) bits. Clears on entry to any mem-wait state (FETCH/MEM_RD/MEM_WR) and on ack. Increments each cycle without ack. When it reaches MEM_TIMEOUT with no ack that cycle: -> TRAP, cause 10. mem_ack arriving in the same cycle as the limit wins (access completes).
- The opcode decode is latched at DECODE. op/funct changes afterwards are ignored until the next FETCH.
- Reset asserted mid-access drops mem_req asynchronously.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release -> state_o INIT for 1 cycle, then FETCH; all outputs 0 during reset and INIT.
- addu (op=0, funct=21h), mem_ack at the first FETCH cycle -> FETCH, DECODE, EXE_R, WB_R over 4 cycles; gpr_wr=1 and gpr_dst=01 only in WB_R.
- lw with mem_ack delayed 3 cycles in MEM_RD -> mem_req held 4 cycles; then MEM_WB with gpr_wr=1, mem2reg=01; total 8 cycles.
- beq with zero=0 then zero=1 -> pc_wr 0 and 1 respectively, npc_sel=01.
- addi with overflow=1 -> gpr_wr=0 in WB_I; next state FETCH.
- op=3Fh -> TRAP, trap_cause=01. Separately, MEM_TIMEOUT=4 with no ack in FETCH -> TRAP after 4 wait cycles, trap_cause=10. Ack on the 4th cycle -> no trap.
